// File: rtl/cg_scheduler.sv
// -----------------------------------------------------------------------------
// cg_scheduler
//   Controller for a bank of integrated clock-gating cells, one per register
//   domain. Each domain gates itself after idle_thresh consecutive idle cycles
//   and is woken on demand. Wake-ups pass through a round-robin arbiter so that
//   at most one domain restarts its clock per cycle.
//
// Ports
//   clk          in   system clock (ungated)
//   rst_n        in   asynchronous active-low reset
//   cfg_en       in   global gating enable; 0 forces every domain awake
//   idle_thresh  in   [IDLE_W] idle cycles before gating; 0 disables gating
//   req          in   [N_DOM] clock request, held by the requester until ack
//   act          in   [N_DOM] activity indication (no handshake)
//   force_on     in   [N_DOM] per-domain gating override
//   cg_en        out  [N_DOM] registered ICG enable
//   ack          out  [N_DOM] domain clock running and stable
//   all_gated    out  registered; 1 when every domain is OFF
// -----------------------------------------------------------------------------
module cg_scheduler #(
  parameter int N_DOM    = 4,
  parameter int IDLE_W   = 8,
  parameter int WAKE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_en,
  input  logic [IDLE_W-1:0] idle_thresh,
  input  logic [N_DOM-1:0]  req,
  input  logic [N_DOM-1:0]  act,
  input  logic [N_DOM-1:0]  force_on,
  output logic [N_DOM-1:0]  cg_en,
  output logic [N_DOM-1:0]  ack,
  output logic              all_gated
);

  localparam int PTR_W  = $clog2(N_DOM);
  localparam int WCNT_W = (WAKE_LAT > 1) ? $clog2(WAKE_LAT) : 1;

  typedef enum logic [1:0] {
    ST_ON   = 2'd0,
    ST_OFF  = 2'd1,
    ST_WAKE = 2'd2
  } dom_state_e;

  // State registers
  dom_state_e        r_state    [N_DOM];
  logic [IDLE_W-1:0] r_idle_cnt [N_DOM];
  logic [WCNT_W-1:0] r_wake_cnt [N_DOM];
  logic [PTR_W-1:0]  r_rr_ptr;
  logic [N_DOM-1:0]  r_cg_en;
  logic [N_DOM-1:0]  r_ack;
  logic              r_all_gated;

  // Next-state and decode
  dom_state_e        w_state_nxt    [N_DOM];
  logic [IDLE_W-1:0] w_idle_cnt_nxt [N_DOM];
  logic [WCNT_W-1:0] w_wake_cnt_nxt [N_DOM];
  logic [PTR_W-1:0]  w_rr_ptr_nxt;
  logic [N_DOM-1:0]  w_cg_en_nxt;
  logic [N_DOM-1:0]  w_ack_nxt;
  logic [N_DOM-1:0]  w_is_off;
  logic [N_DOM-1:0]  w_busy;
  logic [N_DOM-1:0]  w_idle;
  logic [N_DOM-1:0]  w_demand;
  logic [N_DOM-1:0]  w_pending;
  logic              w_gating_ok;
  logic [IDLE_W-1:0] w_thresh_m1;
  logic              w_hi_vld;
  logic [PTR_W-1:0]  w_hi_idx;
  logic              w_lo_vld;
  logic [PTR_W-1:0]  w_lo_idx;
  logic              w_grant_vld;
  logic [PTR_W-1:0]  w_grant_idx;

  assign w_gating_ok = cfg_en && (idle_thresh != '0);
  // Only consulted when w_gating_ok is set, so idle_thresh >= 1 and no wrap.
  assign w_thresh_m1 = idle_thresh - IDLE_W'(1);
  assign w_busy      = req | act | force_on;
  assign w_idle      = ~w_busy & {N_DOM{w_gating_ok}};
  assign w_demand    = w_busy | {N_DOM{~cfg_en}};

  always_comb begin
    for (int i = 0; i < N_DOM; i++) begin
      w_is_off[i]  = (r_state[i] == ST_OFF);
      w_pending[i] = w_is_off[i] && w_demand[i];
    end
  end

  // Round-robin arbiter: the lowest pending index at or above rr_ptr wins;
  // if there is none, the search wraps to the lowest pending index overall.
  // Both searches run descending so the last hit is the lowest index.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    w_hi_vld = 1'b0;
    w_hi_idx = '0;
    w_lo_vld = 1'b0;
    w_lo_idx = '0;
    for (int i = N_DOM - 1; i >= 0; i--) begin
      if (w_pending[i]) begin
        w_lo_vld = 1'b1;
        w_lo_idx = PTR_W'(i);
        if (PTR_W'(i) >= r_rr_ptr) begin
          w_hi_vld = 1'b1;
          w_hi_idx = PTR_W'(i);
        end
      end
    end
    w_grant_vld = w_hi_vld || w_lo_vld;
    w_grant_idx = w_hi_vld ? w_hi_idx : w_lo_idx;

    w_rr_ptr_nxt = r_rr_ptr;
    if (w_grant_vld) begin
      w_rr_ptr_nxt = (w_grant_idx == PTR_W'(N_DOM - 1)) ? '0
                                                        : w_grant_idx + PTR_W'(1);
    end
  end

  // Per-domain ON / OFF / WAKE next-state logic
  always_comb begin
    for (int i = 0; i < N_DOM; i++) begin
      w_state_nxt[i]    = r_state[i];
      w_idle_cnt_nxt[i] = r_idle_cnt[i];
      w_wake_cnt_nxt[i] = r_wake_cnt[i];

      case (r_state[i])
        ST_ON: begin
          if (w_idle[i]) begin
            // Comparing against thresh-1 on the current idle cycle gates after
            // exactly idle_thresh idle cycles, and reacts at once to a lowered
            // threshold.
            if (r_idle_cnt[i] >= w_thresh_m1) begin
              w_state_nxt[i]    = ST_OFF;
              w_idle_cnt_nxt[i] = '0;
            end else if (r_idle_cnt[i] != '1) begin
              w_idle_cnt_nxt[i] = r_idle_cnt[i] + IDLE_W'(1);
            end
          end else begin
            w_idle_cnt_nxt[i] = '0;
          end
        end
        ST_OFF: begin
          if (w_grant_vld && (w_grant_idx == PTR_W'(i))) begin
            w_state_nxt[i]    = ST_WAKE;
            w_wake_cnt_nxt[i] = '0;
          end
        end
        ST_WAKE: begin
          // A wake always completes, even if demand has gone away meanwhile.
          if (r_wake_cnt[i] == WCNT_W'(WAKE_LAT - 1)) begin
            w_state_nxt[i]    = ST_ON;
            w_idle_cnt_nxt[i] = '0;
          end else begin
            w_wake_cnt_nxt[i] = r_wake_cnt[i] + WCNT_W'(1);
          end
        end
        default: begin
          w_state_nxt[i]    = ST_ON;
          w_idle_cnt_nxt[i] = '0;
          w_wake_cnt_nxt[i] = '0;
        end
      endcase

      // Outputs are decoded from the next state and registered, so the ICG
      // enable never sees a combinational glitch.
      w_cg_en_nxt[i] = (w_state_nxt[i] != ST_OFF);
      w_ack_nxt[i]   = (w_state_nxt[i] == ST_ON);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the per-domain arrays are small register files that must start
      // in a known ON state, so each element is reset explicitly.
      for (int i = 0; i < N_DOM; i++) begin
        r_state[i]    <= ST_ON;
        r_idle_cnt[i] <= '0;
        r_wake_cnt[i] <= '0;
      end
      r_rr_ptr    <= '0;
      r_cg_en     <= '1;
      r_ack       <= '1;
      r_all_gated <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments for all state so every flop samples the
      // values from before this edge, independent of statement order.
      for (int i = 0; i < N_DOM; i++) begin
        r_state[i]    <= w_state_nxt[i];
        r_idle_cnt[i] <= w_idle_cnt_nxt[i];
        r_wake_cnt[i] <= w_wake_cnt_nxt[i];
      end
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_cg_en     <= w_cg_en_nxt;
      r_ack       <= w_ack_nxt;
      // Reflects the state held before this edge, so it trails the last
      // domain turning OFF by one cycle.
      r_all_gated <= &w_is_off;
    end
  end

  assign cg_en     = r_cg_en;
  assign ack       = r_ack;
  assign all_gated = r_all_gated;

endmodule
